sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO that replaces the fixed 128-bit write FIFO behind the write-channel BFM. It adds configurable width and depth, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. Its signal names match the existing FIFO interface (wr, rd, full, empty, fifo_cnt, D_in, D_out), so the interface and BFMs can bind to it directly.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_ram.sv | 22 ++
 rtl/sync_fifo_param.sv | 114 +++++++++++
 tb/tb_sync_fifo_param.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types, width helper and parameter sanity checks for the parametrised FIFO.
package fifo_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit thresh_ok(input int depth, input int af, input int ae);
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous indexed read port.
module fifo_ram #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with threshold flags, sticky error flags and selectable
// standard (registered) or first-word-fall-through read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    wr,
  input  logic [DATA_W-1:0]       D_in,
  input  logic                    rd,
  output logic [DATA_W-1:0]       D_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [cnt_w(DEPTH)-1:0] fifo_cnt,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clr_err
);

  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  if (!depth_ok(DEPTH)) begin : g_depth_chk
    $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
  end
  if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_thresh_chk
    $error("sync_fifo_param: AF_THRESH or AE_THRESH out of range");
  end

  logic [CW-1:0]     wr_ptr, rd_ptr, cnt_q, cnt_nxt;
  logic              full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] ram_rdata;

  // A full FIFO is never empty, so wr+rd while full always pops as well.
  assign wr_acc = wr && (!full_q || rd);
  assign rd_acc = rd && !empty_q;

  always_comb begin
    cnt_nxt = cnt_q;
    if (wr_acc && !rd_acc)      cnt_nxt = cnt_q + CW'(1);
    else if (!wr_acc && rd_acc) cnt_nxt = cnt_q - CW'(1);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + CW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + CW'(1);
      cnt_q   <= cnt_nxt;
      full_q  <= (cnt_nxt == DEPTH_C);
      empty_q <= (cnt_nxt == '0);
      af_q    <= (cnt_nxt >= AF_C);
      ae_q    <= (cnt_nxt <= AE_C);
      // A fresh error wins over a same-cycle clear.
      ovf_q   <= (ovf_q && !clr_err) || (wr && full_q && !rd);
      udf_q   <= (udf_q && !clr_err) || (rd && empty_q);
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clock   (clock),
    .we      (wr_acc),
    .wr_idx  (wr_ptr[AW-1:0]),
    .wr_data (D_in),
    .rd_idx  (rd_ptr[AW-1:0]),
    .rd_data (ram_rdata)
  );

  if (MODE == FIFO_FWFT) begin : g_fwft
    // Gate to zero while empty so reset shows 0 instead of unreset memory.
    assign D_out = empty_q ? '0 : ram_rdata;
  end else begin : g_std
    logic [DATA_W-1:0] dout_q;
    always_ff @(posedge clock or negedge rst) begin
      if (!rst)        dout_q <= '0;
      else if (rd_acc) dout_q <= ram_rdata;
    end
    assign D_out = dout_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign fifo_cnt     = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed scoreboard bench: one standard-mode and one FWFT instance, each checked every cycle.
module tb_sync_fifo_param;

  logic         clock = 1'b0;
  logic         rst   = 1'b0;

  logic         wr0 = 0, rd0 = 0, clr0 = 0;
  logic [127:0] din0 = '0, dout0;
  logic         full0, empty0, af0, ae0, ovf0, udf0;
  logic [4:0]   cnt0;

  logic         wr1 = 0, rd1 = 0, clr1 = 0;
  logic [127:0] din1 = '0, dout1;
  logic         full1, empty1, af1, ae1, ovf1, udf1;
  logic [4:0]   cnt1;

  int checks   = 0;
  int failures = 0;

  int           mcnt [2];
  bit           movf [2];
  bit           mudf [2];
  logic [127:0] mdout0;
  logic [127:0] q0 [$];
  logic [127:0] q1 [$];

  always #5 clock = ~clock;

  sync_fifo_param #(.FWFT(0)) u_std (
    .clock(clock), .rst(rst), .wr(wr0), .D_in(din0), .rd(rd0), .D_out(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .fifo_cnt(cnt0), .overflow(ovf0), .underflow(udf0), .clr_err(clr0)
  );

  sync_fifo_param #(.FWFT(1)) u_fwft (
    .clock(clock), .rst(rst), .wr(wr1), .D_in(din1), .rd(rd1), .D_out(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .fifo_cnt(cnt1), .overflow(ovf1), .underflow(udf1), .clr_err(clr1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0;
      movf[i] = 0;
      mudf[i] = 0;
    end
    mdout0 = '0;
    q0.delete();
    q1.delete();
  endtask

  task automatic check_dut(input bit f);
    string s;
    s = f ? "fwft" : "std";
    chk({s, ".fifo_cnt"},     f ? 128'(cnt1) : 128'(cnt0), 128'(mcnt[f]));
    chk({s, ".empty"},        f ? empty1 : empty0, 128'(mcnt[f] == 0));
    chk({s, ".full"},         f ? full1  : full0,  128'(mcnt[f] == 16));
    chk({s, ".almost_full"},  f ? af1    : af0,    128'(mcnt[f] >= 14));
    chk({s, ".almost_empty"}, f ? ae1    : ae0,    128'(mcnt[f] <= 2));
    chk({s, ".overflow"},     f ? ovf1   : ovf0,   128'(movf[f]));
    chk({s, ".underflow"},    f ? udf1   : udf0,   128'(mudf[f]));
    if (!f)
      chk("std.D_out", dout0, mdout0);
    else if (mcnt[1] > 0)
      chk("fwft.D_out", dout1, q1[0]);
  endtask

  // One clock of stimulus on DUT f; inputs return to idle after the edge.
  task automatic cyc(input bit f, input bit w, input bit r, input bit clr, input logic [127:0] d);
    bit fl, em, wa, ra, oe, ue;
    fl = (mcnt[f] == 16);
    em = (mcnt[f] == 0);
    wa = w && (!fl || r);
    ra = r && !em;
    oe = w && fl && !r;
    ue = r && em;
    if (!f) begin
      wr0 = w; rd0 = r; clr0 = clr; din0 = d;
      if (ra) mdout0 = q0.pop_front();
      if (wa) q0.push_back(d);
    end else begin
      wr1 = w; rd1 = r; clr1 = clr; din1 = d;
      if (ra) void'(q1.pop_front());
      if (wa) q1.push_back(d);
    end
    @(posedge clock);
    #1;
    wr0 = 0; rd0 = 0; clr0 = 0;
    wr1 = 0; rd1 = 0; clr1 = 0;
    mcnt[f] = mcnt[f] + int'(wa) - int'(ra);
    movf[f] = (movf[f] && !clr) || oe;
    mudf[f] = (mudf[f] && !clr) || ue;
    check_dut(f);
  endtask

  initial begin
    model_reset();
    #12;
    check_dut(0);
    check_dut(1);
    chk("fwft.D_out_reset", dout1, 128'h0);
    rst = 1'b1;

    // Fill to full, then overflow and clear interplay
    for (int i = 1; i <= 16; i++) cyc(0, 1, 0, 0, 128'(i));
    cyc(0, 1, 0, 0, 128'h99);
    cyc(0, 1, 0, 1, 128'h9A);
    cyc(0, 0, 0, 1, '0);

    // Drain in order, then underflow
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, '0);
    cyc(0, 0, 1, 0, '0);
    cyc(0, 0, 0, 1, '0);

    // Empty corner: write accepted, read rejected
    cyc(0, 1, 1, 0, 128'h50);
    cyc(0, 0, 0, 1, '0);

    // Stream at occupancy 8 so pointers wrap several times
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 128'(32'h60 + i));
    for (int i = 0; i < 40; i++) cyc(0, 1, 1, 0, 128'(32'h1000 + i));

    // Full corner: simultaneous wr and rd both accepted
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 128'(32'h2000 + i));
    cyc(0, 1, 1, 0, 128'hF00D);
    cyc(0, 1, 1, 0, 128'hF00E);
    for (int i = 0; i < 11; i++) cyc(0, 0, 1, 0, '0);

    // FWFT: data visible without rd, rd pops
    cyc(1, 1, 0, 0, 128'hA5);
    cyc(1, 0, 1, 0, '0);
    cyc(1, 1, 1, 0, 128'hC7);
    cyc(1, 0, 0, 1, '0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 128'(32'hB1 + i));
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, '0);
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 0, 128'(32'h300 + i));
    cyc(1, 1, 1, 0, 128'h3FF);
    cyc(1, 1, 0, 0, 128'h3FE);
    for (int i = 0; i < 11; i++) cyc(1, 0, 1, 0, '0);

    // Asynchronous reset in the high phase with fifo_cnt=5 on both instances
    chk("std.cnt_before_reset", 128'(cnt0), 128'd5);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_dut(0);
    check_dut(1);
    chk("fwft.D_out_reset", dout1, 128'h0);
    #2;
    rst = 1'b1;

    cyc(0, 1, 0, 0, 128'h77);
    cyc(0, 0, 1, 0, '0);
    cyc(1, 1, 0, 0, 128'h88);
    cyc(1, 0, 1, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
